// File: rtl/keygen_mult_scheduler.sv
// Baby-Kyber keygen sequencer: shares one external polynomial multiplier
// across the four A_k*s products, then reduces each row mod Q and adds e.
module keygen_mult_scheduler #(
  parameter int N       = 4,
  parameter int Q       = 17,
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*N*W-1:0]     a_flat,
  input  logic [2*N*W-1:0]     s_flat,
  input  logic [2*N*W-1:0]     e_flat,
  output logic                 mul_start,
  output logic [N*W-1:0]       mul_a,
  output logic [N*W-1:0]       mul_b,
  input  logic                 mul_done,
  input  logic [N*W-1:0]       mul_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [2*N*W-1:0]     t_flat
);

  localparam int AW = W + 2;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic signed [AW-1:0] QS = AW'(Q);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_REDUCE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [1:0]         job_q, job_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [4*N*W-1:0]   a_q, a_d;
  logic [2*N*W-1:0]   s_q, s_d;
  logic [2*N*W-1:0]   e_q, e_d;
  logic [2*N*W-1:0]   t_q, t_d;
  logic signed [AW-1:0] acc_q [2][N];
  logic signed [AW-1:0] acc_d [2][N];
  logic               row;

  // Reduced residue lies in [0,Q-1]; e is added unreduced.
  function automatic logic [W-1:0] red(
    input logic signed [AW-1:0] v,
    input logic [W-1:0]         e
  );
    logic signed [AW-1:0] r;
    r = v % QS;
    r = (r + QS) % QS;
    return r[W-1:0] + e;
  endfunction

  assign row = job_q[1];

  always_comb begin
    state_d = state_q;
    job_d   = job_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    s_d     = s_q;
    e_d     = e_q;
    t_d     = t_q;
    acc_d   = acc_q;
    unique case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          a_d   = a_flat;
          s_d   = s_flat;
          e_d   = e_flat;
          job_d = '0;
          for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
              acc_d[r][i] = '0;
            end
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done) begin
          for (int i = 0; i < N; i++) begin
            acc_d[row][i] = acc_q[row][i]
              + AW'($signed(mul_out[i*W +: W]));
          end
          if (job_q[0]) begin
            state_d = S_REDUCE;
          end else begin
            job_d   = job_q + 2'd1;
            state_d = S_ISSUE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_d = S_ERROR;
          end
        end
      end
      S_REDUCE: begin
        for (int i = 0; i < N; i++) begin
          t_d[(int'(row)*N + i)*W +: W] = red(acc_q[row][i],
            e_q[(int'(row)*N + i)*W +: W]);
        end
        if (!row) begin
          job_d   = job_q + 2'd1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      job_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      s_q     <= '0;
      e_q     <= '0;
      t_q     <= '0;
      for (int r = 0; r < 2; r++) begin
        for (int i = 0; i < N; i++) begin
          acc_q[r][i] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      job_q   <= job_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      s_q     <= s_d;
      e_q     <= e_d;
      t_q     <= t_d;
      acc_q   <= acc_d;
    end
  end

  // Operands track the captured data and job, so they hold through WAIT.
  assign mul_a     = a_q[int'(job_q)*N*W +: N*W];
  assign mul_b     = s_q[int'(job_q[0])*N*W +: N*W];
  assign mul_start = (state_q == S_ISSUE);
  assign busy      = (state_q == S_ISSUE) || (state_q == S_WAIT)
                  || (state_q == S_REDUCE);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERROR);
  assign t_flat    = t_q;

endmodule

// File: tb/tb_keygen_mult_scheduler.sv
// Bench for keygen_mult_scheduler: multiplier responder plus
// a polynomial-level reference model of t = A*s + e.
module tb_keygen_mult_scheduler;

  localparam int N  = 4;
  localparam int Q  = 17;
  localparam int W  = 32;
  localparam int TO = 8;
  localparam int PW = N * W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [4*PW-1:0] a_flat = '0;
  logic [2*PW-1:0] s_flat = '0;
  logic [2*PW-1:0] e_flat = '0;
  logic mul_start;
  logic [PW-1:0] mul_a, mul_b;
  logic mul_done;
  logic [PW-1:0] mul_out;
  logic busy, done, err;
  logic [2*PW-1:0] t_flat;

  always #5 clk = ~clk;

  keygen_mult_scheduler #(.N(N), .Q(Q), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_flat(a_flat), .s_flat(s_flat), .e_flat(e_flat),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_out(mul_out),
    .busy(busy), .done(done), .err(err), .t_flat(t_flat)
  );

  int n_assert = 0;
  int n_fail = 0;

  // Responder controls, written only by the main sequence.
  int lat = 1;
  int hang_job = -1;
  int run_seq = 0;
  int stray_req = 0;
  bit ovr_en = 1'b0;
  logic [PW-1:0] ovr_arr [4];

  // Responder-owned state.
  int seen_seq = 0;
  int stray_ack = 0;
  int job_idx = 0;
  int pend = -1;
  logic [PW-1:0] pend_prod;
  logic [PW-1:0] log_a [$];
  logic [PW-1:0] log_b [$];

  function automatic longint co(input logic [4*PW-1:0] v, input int idx);
    logic [W-1:0] x;
    x = v[idx*W +: W];
    return longint'($signed(x));
  endfunction

  // Negacyclic product in Z[x]/(x^N+1).
  function automatic logic [PW-1:0] polymul(input logic [PW-1:0] a,
                                            input logic [PW-1:0] b);
    longint c [N];
    logic [PW-1:0] r;
    for (int i = 0; i < N; i++) c[i] = 0;
    for (int j = 0; j < N; j++) begin
      for (int k = 0; k < N; k++) begin
        if (j + k < N) c[j+k] += co(a, j) * co(b, k);
        else c[j+k-N] -= co(a, j) * co(b, k);
      end
    end
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(c[i]);
    return r;
  endfunction

  function automatic logic [2*PW-1:0] model(input logic [4*PW-1:0] a,
      input logic [2*PW-1:0] s, input logic [2*PW-1:0] e,
      input logic [2*PW-1:0] prev, input int rows);
    logic [2*PW-1:0] t;
    logic [PW-1:0] p0, p1;
    longint sum, rm;
    t = prev;
    for (int r = 0; r < rows; r++) begin
      p0 = polymul(a[(2*r)*PW +: PW], s[0 +: PW]);
      p1 = polymul(a[(2*r+1)*PW +: PW], s[PW +: PW]);
      for (int i = 0; i < N; i++) begin
        sum = co(p0, i) + co(p1, i);
        rm = sum % Q;
        if (rm < 0) rm += Q;
        t[(r*N+i)*W +: W] = W'(rm + co(e, r*N+i));
      end
    end
    return t;
  endfunction

  function automatic logic [PW-1:0] poly(input int c0, input int c1,
                                         input int c2, input int c3);
    return {W'(c3), W'(c2), W'(c1), W'(c0)};
  endfunction

  function automatic logic [PW-1:0] rnd_poly(input int lo, input int hi);
    logic [PW-1:0] p;
    for (int i = 0; i < N; i++)
      p[i*W +: W] = W'(int'($urandom_range(0, hi - lo)) + lo);
    return p;
  endfunction

  always @(negedge clk) begin
    mul_done = 1'b0;
    if (run_seq != seen_seq) begin
      seen_seq = run_seq;
      job_idx = 0;
      log_a.delete();
      log_b.delete();
    end
    if (!rst_n) pend = -1;
    if (stray_req != stray_ack) begin
      stray_ack = stray_req;
      mul_done = 1'b1;
      mul_out = {N{32'h0000_0007}};
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        mul_done = 1'b1;
        mul_out = pend_prod;
        pend = -1;
      end
    end
    if (mul_start && rst_n) begin
      log_a.push_back(mul_a);
      log_b.push_back(mul_b);
      if (job_idx != hang_job) begin
        pend = lat;
        if (ovr_en && job_idx < 4) pend_prod = ovr_arr[job_idx];
        else pend_prod = polymul(mul_a, mul_b);
      end
      job_idx++;
    end
  end

  task automatic chk(input string tag, input logic [2*PW-1:0] obs,
                     input logic [2*PW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int bcnt, bfirst, mscnt;
  logic err1;

  task automatic run(input int L, input int inj,
                     input logic [4*PW-1:0] alt_a, input int rstc,
                     output int dcyc, output int ecyc);
    dcyc = -1;
    ecyc = -1;
    bcnt = 0;
    bfirst = -1;
    mscnt = 0;
    err1 = 1'bx;
    lat = L;
    run_seq++;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        err1 = err;
      end
      if (busy) begin
        bcnt++;
        if (bfirst < 0) bfirst = k;
      end
      if (mul_start) mscnt++;
      if (done) begin
        dcyc = k;
        break;
      end
      if (err) begin
        ecyc = k;
        break;
      end
      if (k == inj) begin
        start = 1'b1;
        a_flat = alt_a;
      end
      if (k == inj + 1) start = 1'b0;
      if (k == rstc) begin
        rst_n = 1'b0;
        #1;
        chk("rst_async_ctrl", {mul_start, busy, done, err}, 0);
        chk("rst_async_ops", {mul_a, mul_b}, 0);
        chk("rst_async_t", t_flat, 0);
        break;
      end
    end
  endtask

  logic [4*PW-1:0] a_sv;
  logic [2*PW-1:0] s_sv, e_sv, exp_t;
  int dc, ec, L;

  task automatic rand_ops();
    for (int k = 0; k < 4; k++) a_flat[k*PW +: PW] = rnd_poly(0, 16);
    s_flat = {rnd_poly(-2, 2), rnd_poly(-2, 2)};
    e_flat = {rnd_poly(-3, 3), rnd_poly(-3, 3)};
    a_sv = a_flat;
    s_sv = s_flat;
    e_sv = e_flat;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {mul_start, busy, done, err}, 0);
    chk("reset_ops", {mul_a, mul_b}, 0);
    chk("reset_t", t_flat, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Routing and latency, L=1
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < N; i++)
        a_flat[(k*N+i)*W +: W] = W'(10*k + i);
    s_flat = {poly(5, 6, 7, 8), poly(1, 2, 3, 4)};
    e_flat = {rnd_poly(-3, 3), rnd_poly(-3, 3)};
    a_sv = a_flat; s_sv = s_flat; e_sv = e_flat;
    run(1, -10, '0, -1, dc, ec);
    chk("route_done_cycle", dc, 11);
    chk("route_busy_cycles", bcnt, 10);
    chk("route_busy_first", bfirst, 1);
    chk("route_mul_starts", mscnt, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("route_mul_a%0d", k), log_a[k], a_sv[k*PW +: PW]);
      chk($sformatf("route_mul_b%0d", k), log_b[k], s_sv[(k%2)*PW +: PW]);
    end
    exp_t = model(a_sv, s_sv, e_sv, '0, 2);
    chk("route_t", t_flat, exp_t);
    @(negedge clk);
    chk("done_one_cycle", {done, busy}, 0);

    // Fixed products: positive accumulate and negative reduction
    ovr_arr[0] = poly(5, 0, 0, 0);
    ovr_arr[1] = poly(20, 0, 0, 0);
    ovr_arr[2] = poly(-3, 16, 0, -17);
    ovr_arr[3] = poly(-20, 1, 0, 0);
    ovr_en = 1'b1;
    e_flat = {poly(-1, 0, 1, 0), poly(1, 0, 0, 0)};
    run(1, -10, '0, -1, dc, ec);
    ovr_en = 1'b0;
    chk("fixed_done_cycle", dc, 11);
    chk("fixed_t0", t_flat[0 +: PW], poly(9, 0, 0, 0));
    chk("fixed_t1", t_flat[PW +: PW], poly(10, 0, 1, 0));
    exp_t = t_flat;

    // L=5 with a start ignored during WAIT of job1
    rand_ops();
    run(5, 9, ~a_sv, -1, dc, ec);
    chk("busy_start_done_cycle", dc, 27);
    chk("busy_start_mul_starts", mscnt, 4);
    exp_t = model(a_sv, s_sv, e_sv, '0, 2);
    chk("busy_start_t", t_flat, exp_t);
    stray_req++;
    repeat (3) @(negedge clk);
    chk("stray_done_ctrl", {mul_start, busy, done, err}, 0);
    chk("stray_done_t", t_flat, exp_t);

    // Timeout on job2
    rand_ops();
    hang_job = 2;
    run(2, -10, '0, -1, dc, ec);
    hang_job = -1;
    chk("timeout_err_cycle", ec, 17);
    chk("timeout_no_done", dc, -1);
    chk("timeout_flags", {err, busy, done}, 3'b100);
    exp_t = model(a_sv, s_sv, e_sv, exp_t, 1);
    chk("timeout_t", t_flat, exp_t);
    repeat (4) @(negedge clk);
    chk("timeout_sticky", {err, busy, mul_start}, 3'b100);
    rand_ops();
    run(1, -10, '0, -1, dc, ec);
    chk("restart_err_clear", err1, 1'b0);
    chk("restart_done_cycle", dc, 11);
    exp_t = model(a_sv, s_sv, e_sv, '0, 2);
    chk("restart_t", t_flat, exp_t);

    // Reset during WAIT of job1, then a clean run
    rand_ops();
    run(3, -10, '0, 7, dc, ec);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_ops();
    run(2, -10, '0, -1, dc, ec);
    chk("post_rst_done_cycle", dc, 15);
    exp_t = model(a_sv, s_sv, e_sv, '0, 2);
    chk("post_rst_t", t_flat, exp_t);

    // Random operands and latencies
    for (int n = 0; n < 4; n++) begin
      L = int'($urandom_range(1, 6));
      rand_ops();
      run(L, -10, '0, -1, dc, ec);
      chk($sformatf("rand%0d_done_cycle", n), dc, 4*L + 7);
      exp_t = model(a_sv, s_sv, e_sv, '0, 2);
      chk($sformatf("rand%0d_t", n), t_flat, exp_t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
